// File: rtl/hamming_enc_ser_tx.sv
// Hamming(15,11) even-parity encoder with single-bit error injection and an
// LSB-first serializer that feeds a receiver shift register directly.
module hamming_enc_ser_tx #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned CODE_W = 15
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [3:0]        err_pos,
    output logic              ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              done,
    output logic [CODE_W-1:0] code_word
);

    // Bit i-1 of a mask is set when position i has parity-group bit k set.
    localparam logic [14:0] MaskP1 = 15'h5555;
    localparam logic [14:0] MaskP2 = 15'h6666;
    localparam logic [14:0] MaskP4 = 15'h7878;
    localparam logic [14:0] MaskP8 = 15'h7F80;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [14:0] shreg_q, shreg_d;
    logic [14:0] code_q, code_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] enc_word;

    always_comb begin
        enc_word     = '0;
        enc_word[2]  = data_in[0];
        enc_word[4]  = data_in[1];
        enc_word[5]  = data_in[2];
        enc_word[6]  = data_in[3];
        enc_word[8]  = data_in[4];
        enc_word[9]  = data_in[5];
        enc_word[10] = data_in[6];
        enc_word[11] = data_in[7];
        enc_word[12] = data_in[8];
        enc_word[13] = data_in[9];
        enc_word[14] = data_in[10];
        // Parity slots are still zero here, so they drop out of their own XOR.
        enc_word[0]  = ^(enc_word & MaskP1);
        enc_word[1]  = ^(enc_word & MaskP2);
        enc_word[3]  = ^(enc_word & MaskP4);
        enc_word[7]  = ^(enc_word & MaskP8);
        for (int i = 0; i < 15; i++) begin
            if (err_pos == 4'(i + 1)) begin
                enc_word[i] = ~enc_word[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    code_d  = enc_word;
                    shreg_d = enc_word;
                    cnt_d   = 4'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                shreg_d = {1'b0, shreg_q[14:1]};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd14) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= StIdle;
            shreg_q <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ready     = (state_q == StIdle);
        ser_valid = (state_q == StShift);
        done      = (state_q == StDone);
        ser_out   = ser_valid & shreg_q[0];
        code_word = code_q;
    end

endmodule

// File: tb/tb_hamming_enc_ser_tx.sv
// Directed and loopback bench for hamming_enc_ser_tx, with a falling-edge
// receiver shift register model and a syndrome-based codeword check.
module tb_hamming_enc_ser_tx;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [10:0] data_in;
    logic [3:0]  err_pos;
    logic        ready;
    logic        ser_out;
    logic        ser_valid;
    logic        done;
    logic [14:0] code_word;

    logic [14:0] rx = '0;
    int checks   = 0;
    int failures = 0;

    hamming_enc_ser_tx #(.DATA_W(11), .CODE_W(15)) dut (
        .clk       (clk),
        .RST       (RST),
        .start     (start),
        .data_in   (data_in),
        .err_pos   (err_pos),
        .ready     (ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .done      (done),
        .code_word (code_word)
    );

    always #5 clk = ~clk;

    // Receiver: samples mid-bit on the falling edge, first bit ends up at bit 0.
    always @(negedge clk) begin
        if (ser_valid) rx <= {ser_out, rx[14:1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // XOR of the positions of every set bit: 0 for a clean codeword.
    function automatic logic [3:0] syndrome(input logic [14:0] w);
        logic [3:0] s = 4'd0;
        for (int p = 1; p <= 15; p++) if (w[p-1]) s ^= 4'(p);
        return s;
    endfunction

    // Data bits sit at every position that is not a power of two, ascending.
    function automatic logic [10:0] extract(input logic [14:0] w);
        logic [10:0] d = '0;
        int j = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = w[p-1];
                j++;
            end
        end
        return d;
    endfunction

    // One frame from IDLE; returns the serial bits seen and the codeword.
    task automatic run_frame(input logic [10:0] d, input logic [3:0] e, input bit full,
                             output logic [14:0] bits, output logic [14:0] cw);
        int nvalid = 0;
        bits = '0;
        data_in = d;
        err_pos = e;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        data_in = 11'h2AA;
        err_pos = 4'd9;
        for (int i = 0; i < 15; i++) begin
            if (ser_valid) nvalid++;
            bits[i] = ser_out;
            tick();
        end
        cw = code_word;
        if (full) begin
            check("valid_cycles", nvalid, 15);
            check("done_cycle16", done, 1'b1);
            check("loopback_rx", rx, code_word);
            tick();
            check("ready_cycle17", ready, 1'b1);
        end else begin
            check("loopback_rx", rx, code_word);
            tick();
        end
    endtask

    logic [14:0] bits, cw;
    logic [10:0] rd;
    logic [3:0]  re;
    int          nv;

    initial begin
        RST = 1'b1; start = 1'b0; data_in = '0; err_pos = '0;
        tick(); tick();
        check("rst_ready", ready, 1'b1);
        check("rst_valid", ser_valid, 1'b0);
        check("rst_code", code_word, 15'h0000);
        RST = 1'b0;
        tick();

        run_frame(11'h001, 4'd0, 1'b1, bits, cw);
        check("d001_code", cw, 15'h0007);
        check("d001_serial", bits, 15'h0007);

        run_frame(11'h7FF, 4'd0, 1'b1, bits, cw);
        check("d7ff_code", cw, 15'h7FFF);
        check("d7ff_serial", bits, 15'h7FFF);

        run_frame(11'h000, 4'd0, 1'b1, bits, cw);
        check("d000_code", cw, 15'h0000);
        check("d000_serial", bits, 15'h0000);

        run_frame(11'h400, 4'd0, 1'b1, bits, cw);
        check("d400_code", cw, 15'h408B);

        run_frame(11'h000, 4'd5, 1'b1, bits, cw);
        check("err5_code", cw, 15'h0010);
        check("err5_serial", bits, 15'h0010);
        check("err5_syndrome", syndrome(rx), 4'd5);

        // start pulsed during SHIFT and during DONE must be ignored
        nv = 0;
        data_in = 11'h001; err_pos = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (ser_valid) nv++;
            start   = (c == 5 || c == 16);
            data_in = 11'h7FF;
            tick();
            start   = 1'b0;
        end
        check("proto_valid_cycles", nv, 15);
        check("proto_code_kept", code_word, 15'h0007);
        check("proto_ready", ready, 1'b1);
        tick();
        check("proto_not_queued", ser_valid, 1'b0);

        // start held high: frames every 17 cycles, one 2-cycle gap between them
        nv = 0;
        data_in = 11'h000; err_pos = 4'd0; start = 1'b1;
        tick();
        for (int c = 1; c <= 34; c++) begin
            if (ser_valid) nv++;
            if (c == 16) check("held_done16", done, 1'b1);
            if (c == 17) check("held_ready17", ready, 1'b1);
            if (c == 18) check("held_valid18", ser_valid, 1'b1);
            if (c == 34) start = 1'b0;
            tick();
        end
        check("held_valid_count", nv, 30);

        // reset mid-SHIFT
        data_in = 11'h7FF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        check("midrst_valid", ser_valid, 1'b0);
        check("midrst_ser_out", ser_out, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_ready", ready, 1'b1);
        check("midrst_code", code_word, 15'h0000);

        // reset and start together: nothing accepted
        RST = 1'b1; start = 1'b1; data_in = 11'h7FF;
        tick();
        RST = 1'b0; start = 1'b0;
        check("rst_start_valid", ser_valid, 1'b0);
        check("rst_start_ready", ready, 1'b1);
        check("rst_start_code", code_word, 15'h0000);
        tick();

        for (int n = 0; n < 200; n++) begin
            rd = 11'($urandom);
            re = (n % 4 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            run_frame(rd, re, 1'b0, bits, cw);
            check("rand_syndrome", syndrome(rx), re);
            check("rand_data", extract(re == 0 ? rx : rx ^ (15'h1 << (re - 1))), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
